// File: rtl/sig_phase_scheduler_if.sv
// Sensor/light bundle for sig_phase_scheduler; the preemption signals exist only
// when SIG_PREEMPT_EN is defined.
interface sig_phase_scheduler_if #(
  parameter int NUM_APPR = 4,
  parameter int AW       = 2
);
  logic [NUM_APPR-1:0]   car_det;
  logic [2*NUM_APPR-1:0] lights;
  logic [AW-1:0]         cur_appr;
  logic [1:0]            phase;
  logic                  grant_pulse;
`ifdef SIG_PREEMPT_EN
  logic                  preempt_req;
  logic [AW-1:0]         preempt_appr;

  modport master (output car_det, preempt_req, preempt_appr,
                  input  lights, cur_appr, phase, grant_pulse);
  modport slave  (input  car_det, preempt_req, preempt_appr,
                  output lights, cur_appr, phase, grant_pulse);
`else
  modport master (output car_det, input lights, cur_appr, phase, grant_pulse);
  modport slave  (input car_det, output lights, cur_appr, phase, grant_pulse);
`endif
endinterface

// File: rtl/sig_phase_scheduler.sv
// Round-robin green-phase scheduler for NUM_APPR approaches with counter-timed
// green/yellow/all-red phases. Optional SIG_PREEMPT_EN adds emergency preemption.
module sig_phase_scheduler #(
  parameter int NUM_APPR  = 4,
  parameter int AW        = 2,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input logic               clock,
  input logic               clear,
  sig_phase_scheduler_if.slave bus
);

  localparam logic [1:0] PH_GREEN  = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd1;
  localparam logic [1:0] PH_ALLRED = 2'd2;

  localparam logic [1:0] L_RED = 2'd0;
  localparam logic [1:0] L_YEL = 2'd1;
  localparam logic [1:0] L_GRN = 2'd2;

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);

  logic [1:0]       phase_q;
  logic [AW-1:0]    cur_q;
  logic [AW-1:0]    nxt_q;
  logic [CNT_W-1:0] timer_q;
  logic             grant_q;

  logic             own_req;
  logic             other_req;
  logic [AW-1:0]    rr_sel;
  logic             green_exit;
  logic [AW-1:0]    next_sel;

  function automatic logic [AW-1:0] wrap_idx(input logic [AW-1:0] c, input int k);
    int s;
    s = int'(c) + k;
    if (s >= NUM_APPR) s = s - NUM_APPR;
    return AW'(s);
  endfunction

  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    rr_sel    = cur_q;
    for (int i = 0; i < NUM_APPR; i++) begin
      if (AW'(i) == cur_q) own_req = bus.car_det[i];
      else if (bus.car_det[i]) other_req = 1'b1;
    end
    // Scan from the farthest offset down so the nearest requester after cur_q wins.
    for (int k = NUM_APPR - 1; k >= 1; k--) begin
      if (bus.car_det[wrap_idx(cur_q, k)]) rr_sel = wrap_idx(cur_q, k);
    end
  end

`ifdef SIG_PREEMPT_EN
  logic preempt_go;
  logic preempt_hold;
  always_comb begin
    preempt_go   = bus.preempt_req && (bus.preempt_appr != cur_q);
    preempt_hold = bus.preempt_req && (bus.preempt_appr == cur_q);
    green_exit   = 1'b0;
    next_sel     = rr_sel;
    if (preempt_go) begin
      green_exit = 1'b1;
      next_sel   = bus.preempt_appr;
    end else if (!preempt_hold) begin
      green_exit = other_req && (timer_q >= GMIN_M1) && (!own_req || (timer_q >= GMAX_M1));
    end
  end
`else
  always_comb begin
    green_exit = other_req && (timer_q >= GMIN_M1) && (!own_req || (timer_q >= GMAX_M1));
    next_sel   = rr_sel;
  end
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      phase_q <= PH_GREEN;
      cur_q   <= '0;
      nxt_q   <= '0;
      timer_q <= '0;
      grant_q <= 1'b0;
    end else begin
      grant_q <= 1'b0;
      case (phase_q)
        PH_GREEN: begin
          if (green_exit) begin
            phase_q <= PH_YELLOW;
            timer_q <= '0;
            nxt_q   <= next_sel;
          end else if (timer_q < GMAX_M1) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        PH_YELLOW: begin
          if (timer_q == YEL_M1) begin
            phase_q <= PH_ALLRED;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`ifdef SIG_PREEMPT_EN
          if (bus.preempt_req) nxt_q <= bus.preempt_appr;
`endif
        end
        PH_ALLRED: begin
          if (timer_q == AR_M1) begin
            phase_q <= PH_GREEN;
            timer_q <= '0;
            cur_q   <= nxt_q;
            grant_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`ifdef SIG_PREEMPT_EN
          if (bus.preempt_req) nxt_q <= bus.preempt_appr;
`endif
        end
        default: begin
          phase_q <= PH_ALLRED;
          timer_q <= '0;
        end
      endcase
    end
  end

  // Only cur_q may leave RED, which keeps the one-non-RED safety invariant structural.
  always_comb begin
    bus.lights = '0;
    for (int i = 0; i < NUM_APPR; i++) begin
      bus.lights[2*i +: 2] = L_RED;
      if (AW'(i) == cur_q) begin
        if (phase_q == PH_GREEN)       bus.lights[2*i +: 2] = L_GRN;
        else if (phase_q == PH_YELLOW) bus.lights[2*i +: 2] = L_YEL;
      end
    end
  end

  assign bus.phase       = (phase_q == 2'd3) ? PH_ALLRED : phase_q;
  assign bus.cur_appr    = cur_q;
  assign bus.grant_pulse = grant_q;

endmodule

// File: tb/tb_sig_phase_scheduler.sv
// Directed bench for sig_phase_scheduler: expected per-cycle outputs are queued
// from the timing plan and popped against the DUT one cycle at a time.
module tb_sig_phase_scheduler;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int W  = 2 + AW + 1 + 2*N;

  localparam logic [1:0] P_G = 2'd0;
  localparam logic [1:0] P_Y = 2'd1;
  localparam logic [1:0] P_R = 2'd2;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  sig_phase_scheduler_if #(.NUM_APPR(N), .AW(AW)) bus ();

  sig_phase_scheduler dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic logic [2*N-1:0] exp_lights(input logic [1:0] ph, input logic [AW-1:0] a);
    logic [2*N-1:0] l;
    l = '0;
    if (ph == P_G)      l[2*a +: 2] = 2'd2;
    else if (ph == P_Y) l[2*a +: 2] = 2'd1;
    return l;
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.phase, bus.cur_appr, bus.grant_pulse, bus.lights};
  endfunction

  task automatic push_seg(input logic [1:0] ph, input logic [AW-1:0] a, input int n,
                          input logic first_grant);
    logic g;
    for (int i = 0; i < n; i++) begin
      g = first_grant && (i == 0);
      exp_q.push_back({ph, a, g, exp_lights(ph, a)});
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (phase,cur,grant,lights)", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input int n);
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL %s c%0d observed=%h expected=<queue empty>", tag, cyc, observed());
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s c%0d", tag, cyc), observed(), e);
      end
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic do_reset(input logic [N-1:0] car);
    clear       = 1'b1;
    bus.car_det = car;
    repeat (2) @(negedge clock);
    check("reset_hold", observed(), {P_G, 2'd0, 1'b0, exp_lights(P_G, 2'd0)});
    clear = 1'b0;
    cyc   = 0;
    exp_q.delete();
  endtask

  initial begin
    clear       = 1'b1;
    bus.car_det = '0;
`ifdef SIG_PREEMPT_EN
    bus.preempt_req  = 1'b0;
    bus.preempt_appr = '0;
`endif

    // Basic handoff 0 -> 2.
    do_reset(4'b0100);
    push_seg(P_G, 2'd0, 4, 1'b0);
    push_seg(P_Y, 2'd0, 3, 1'b0);
    push_seg(P_R, 2'd0, 2, 1'b0);
    push_seg(P_G, 2'd2, 4, 1'b1);
    run("handoff", 13);

    // Own request held: green extends to GREEN_MAX.
    do_reset(4'b0011);
    push_seg(P_G, 2'd0, 16, 1'b0);
    push_seg(P_Y, 2'd0, 3, 1'b0);
    push_seg(P_R, 2'd0, 2, 1'b0);
    push_seg(P_G, 2'd1, 2, 1'b1);
    run("maxgreen", 23);

    // No competing request: green holds.
    do_reset(4'b0001);
    push_seg(P_G, 2'd0, 100, 1'b0);
    run("nocomp", 100);

    // Reach approach 3, then wrap to 0 and on to 2.
    do_reset(4'b1000);
    push_seg(P_G, 2'd0, 4, 1'b0);
    push_seg(P_Y, 2'd0, 3, 1'b0);
    push_seg(P_R, 2'd0, 2, 1'b0);
    push_seg(P_G, 2'd3, 1, 1'b1);
    run("rr_a", 10);
    bus.car_det = 4'b0101;
    push_seg(P_G, 2'd3, 3, 1'b0);
    push_seg(P_Y, 2'd3, 3, 1'b0);
    push_seg(P_R, 2'd3, 2, 1'b0);
    push_seg(P_G, 2'd0, 16, 1'b1);
    push_seg(P_Y, 2'd0, 3, 1'b0);
    push_seg(P_R, 2'd0, 2, 1'b0);
    push_seg(P_G, 2'd2, 2, 1'b1);
    run("rr_b", 31);

    // Asynchronous clear in the middle of yellow.
    do_reset(4'b0100);
    push_seg(P_G, 2'd0, 4, 1'b0);
    push_seg(P_Y, 2'd0, 2, 1'b0);
    run("pre_clr", 6);
    #2;
    clear = 1'b1;
    #1;
    check("async_clr", observed(), {P_G, 2'd0, 1'b0, exp_lights(P_G, 2'd0)});
    @(negedge clock);
    do_reset(4'b0100);
    push_seg(P_G, 2'd0, 4, 1'b0);
    push_seg(P_Y, 2'd0, 3, 1'b0);
    push_seg(P_R, 2'd0, 2, 1'b0);
    push_seg(P_G, 2'd2, 1, 1'b1);
    run("post_clr", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sig_phase_scheduler.md
Name: sig_phase_scheduler

Overview:
Multi-approach intersection phase scheduler. It shares the single green phase between NUM_APPR road approaches, each with a car sensor. Round-robin arbitration selects the next approach. Counter-based timers enforce minimum/maximum green, yellow and all-red intervals with no delay loops. It drives one 2-bit light per approach using the signal encoding RED=0, YELLOW=1, GREEN=2 (3 unused).

Parameters:
NUM_APPR, 4, number of approaches (2..8)
AW, 2, approach index width; must satisfy 2**AW >= NUM_APPR
CNT_W, 8, phase timer width
GREEN_MIN, 4, minimum green cycles (>=1)
GREEN_MAX, 16, maximum green cycles while others wait (>=GREEN_MIN)
YELLOW_T, 3, yellow cycles (>=1)
ALLRED_T, 2, all-red cycles (>=1)

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous, active-high reset
car_det  input  NUM_APPR  bit i = car waiting/present on approach i
lights  output  2*NUM_APPR  light of approach i at bits [2i+1:2i]
cur_appr  output  AW  approach currently owning the phase
phase  output  2  0=GREEN, 1=YELLOW, 2=ALLRED
grant_pulse  output  1  one-cycle pulse in first cycle of a newly granted green

Behaviour:
- Interface: one clock (clock); reset clear is asynchronous and active-high.
- Registered state: phase, cur_appr, nxt_appr, timer. All outputs decode from registers only; no combinational path from car_det to any output.
- Reset values: phase=GREEN, cur_appr=0, nxt_appr=0, timer=0, grant_pulse=0, lights = approach 0 GREEN, all others RED.
- timer clears to 0 on every phase change and increments otherwise. In GREEN it saturates at GREEN_MAX-1.
- other_req = OR of car_det excluding cur_appr.
- GREEN -> YELLOW at a rising edge when all of the following hold:
  - other_req=1
  - timer >= GREEN_MIN-1
  - car_det[cur_appr]=0, or timer >= GREEN_MAX-1
- On that edge nxt_appr latches the first requesting approach found searching cur_appr+1, cur_appr+2, ..., wrapping past NUM_APPR-1 to 0. cur_appr is never selected.
- With no other request, green holds indefinitely.
- YELLOW -> ALLRED when timer = YELLOW_T-1.
- ALLRED -> GREEN when timer = ALLRED_T-1. On that edge cur_appr <= nxt_appr and grant_pulse is set for exactly one cycle.
- car_det changes during YELLOW/ALLRED do not alter nxt_appr. A granted approach whose request dropped still receives GREEN_MIN of green.
- Resulting phase durations: green >= GREEN_MIN; yellow exactly YELLOW_T; all-red exactly ALLRED_T.
- Lights: cur_appr shows GREEN in phase GREEN and YELLOW in phase YELLOW. Every other approach, and all approaches in ALLRED, show RED.
- Safety invariant: at most one approach is non-RED in any cycle.
- clear asserted mid-phase returns immediately (asynchronously) to the reset state, regardless of phase.
- The value 3 on phase and on any light is never produced. An illegal phase register value recovers to ALLRED with timer=0.

Optional Feature:
Macro SIG_PREEMPT_EN (emergency-vehicle preemption).
- Defined: adds inputs preempt_req (1) and preempt_appr (AW).
  - In GREEN with preempt_req=1 and cur_appr != preempt_appr: go to YELLOW at the next edge, ignoring GREEN_MIN/GREEN_MAX, with nxt_appr <= preempt_appr.
  - In GREEN with cur_appr == preempt_appr: no exit while preempt_req=1.
  - In YELLOW/ALLRED with preempt_req=1: nxt_appr is overwritten with preempt_appr each cycle. Yellow and all-red durations are never shortened.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset/basic handoff (defaults), cycle 0 = first edge after clear deasserts, car_det=4'b0100 held -> approach 0 GREEN cycles 0-3, YELLOW 4-6, all RED 7-8; approach 2 GREEN from cycle 9, grant_pulse=1 only in cycle 9, cur_appr=2.
- Max-green extension: car_det=4'b0011 held from reset -> approach 0 GREEN 16 cycles (0-15), YELLOW 16-18, ALLRED 19-20, approach 1 GREEN at 21.
- No competition: car_det=4'b0001 for 100 cycles -> approach 0 stays GREEN, phase=0, no grant_pulse.
- Round-robin wrap: cur_appr=3 in GREEN, car_det=4'b0101 -> nxt grant to approach 0; next arbitration (same car_det) grants approach 2, never 3 twice in a row.
- Async reset mid-YELLOW: assert clear between edges while phase=1 -> lights show approach 0 GREEN, others RED immediately before the next edge, timer=0.
- SIG_PREEMPT_EN: approach 0 green at timer=1, preempt_req=1, preempt_appr=3 -> YELLOW next cycle; after 3+2 cycles approach 3 GREEN. It holds while preempt_req=1 even with car_det=4'b0111.
